// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM SRAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter and access sequencer for a
// single-ported SRAM with a programmable strobe hold time.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | sample requests, pick winner, launch SRAM strobes or flag error
//   ACCESS | SRAM strobes held; wait_cnt counts down to terminal count 0
//   DONE   | one-cycle ack (and err) to the winning port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_we,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              if_ack,
    output logic              dm_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              if_err,
    output logic              dm_err,
    output logic              busy,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic              grant;
    logic              last_grant;
    logic              lat_err;

    logic              req_any;
    logic              pick_dm;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_mis;
    logic              access_end;

    always_comb begin
        req_any    = if_req | dm_req;
        // On a tie the port that did not win last time goes first.
        pick_dm    = dm_req & (~if_req | (last_grant == PORT_IF));
        sel_addr   = pick_dm ? dm_addr : if_addr;
        sel_mis    = (sel_addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
        access_end = (wait_cnt == 4'd0);

        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = sel_mis ? DONE : ACCESS;
            ACCESS:  if (access_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy   = (state != IDLE);
        if_ack = (state == DONE) && (grant == PORT_IF);
        dm_ack = (state == DONE) && (grant == PORT_DM);
        if_err = if_ack & lat_err;
        dm_err = dm_ack & lat_err;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            grant      <= PORT_IF;
            last_grant <= PORT_IF;
            lat_err    <= 1'b0;
            sram_cs    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant    <= pick_dm;
                        lat_err  <= sel_mis;
                        wait_cnt <= 4'(WAIT_CYCLES);
                        if (sel_mis) begin
                            if (pick_dm) dm_rdata <= '0;
                            else         if_rdata <= '0;
                        end else begin
                            sram_cs   <= 1'b1;
                            sram_oe   <= ~(pick_dm & dm_we);
                            sram_we   <= pick_dm & dm_we;
                            sram_addr <= sel_addr;
                            sram_din  <= pick_dm ? dm_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (access_end) begin
                        // addr/din stay put so the write closes cleanly
                        sram_cs <= 1'b0;
                        sram_oe <= 1'b0;
                        sram_we <= 1'b0;
                        if (sram_oe) begin
                            if (grant == PORT_DM) dm_rdata <= sram_dout;
                            else                  if_rdata <= sram_dout;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: last_grant <= grant;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a transaction-level model,
// run on three builds (WAIT_CYCLES = 1, 0, 15) sharing one SRAM model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req [3];
    logic        dm_req [3];
    logic        dm_we  [3];
    logic [31:0] if_addr [3];
    logic [31:0] dm_addr [3];
    logic [31:0] dm_wdata [3];
    logic        if_ack [3];
    logic        dm_ack [3];
    logic        if_err [3];
    logic        dm_err [3];
    logic        busy [3];
    logic        sram_cs [3];
    logic        sram_oe [3];
    logic        sram_we [3];
    logic [31:0] if_rdata [3];
    logic [31:0] dm_rdata [3];
    logic [31:0] sram_addr [3];
    logic [31:0] sram_din [3];
    logic [31:0] sram_dout [3];

    logic [31:0] sram_mem [256];
    logic        mem_load;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rd [3][2];
    int          lg [3];

    function automatic int wc(int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
    endfunction

    function automatic logic [31:0] init_val(int i);
        return (i == 1) ? 32'h2001_0005 : ((32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F);
    endfunction

    function automatic int lat(int k, logic [31:0] a);
        return (a[1:0] != 2'b00) ? 1 : wc(k) + 2;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 15)),
            .ADDR_W(32),
            .DATA_W(32)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]),
            .dm_req(dm_req[g]), .dm_addr(dm_addr[g]), .dm_we(dm_we[g]), .dm_wdata(dm_wdata[g]),
            .if_ack(if_ack[g]), .dm_ack(dm_ack[g]),
            .if_rdata(if_rdata[g]), .dm_rdata(dm_rdata[g]),
            .if_err(if_err[g]), .dm_err(dm_err[g]), .busy(busy[g]),
            .sram_cs(sram_cs[g]), .sram_oe(sram_oe[g]), .sram_we(sram_we[g]),
            .sram_addr(sram_addr[g]), .sram_din(sram_din[g]), .sram_dout(sram_dout[g])
        );
        assign sram_dout[g] = sram_mem[sram_addr[g][9:2]];
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
        end else begin
            for (int k = 0; k < 3; k++)
                if (sram_cs[k] && sram_we[k]) sram_mem[sram_addr[k][9:2]] <= sram_din[k];
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(int k);
        chk("zero_ctl", {if_ack[k], dm_ack[k], if_err[k], dm_err[k], busy[k],
                         sram_cs[k], sram_oe[k], sram_we[k]}, 64'd0);
        chk("zero_rdata", {if_rdata[k], dm_rdata[k]}, 64'd0);
        chk("zero_sram_bus", {sram_addr[k], sram_din[k]}, 64'd0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            lg[k] = 0;
            exp_rd[k][0] = '0;
            exp_rd[k][1] = '0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic transact(input int k, input bit ion, input logic [31:0] ia,
                            input bit don, input logic [31:0] da,
                            input bit dwe, input logic [31:0] dwd);
        int cur, nleft, c, exp_c, p;
        int n_cs, n_we, n_oe, e_cs, e_we, e_oe;
        logic        pwe;
        logic [31:0] pad, pdin, a;
        bit          w, mis;
        if_req[k] = ion; if_addr[k] = ia;
        dm_req[k] = don; dm_addr[k] = da; dm_we[k] = dwe; dm_wdata[k] = dwd;
        if (ion && don) cur = (lg[k] == 0) ? 1 : 0;
        else            cur = don ? 1 : 0;
        nleft = int'(ion) + int'(don);
        exp_c = lat(k, (cur == 1) ? da : ia);
        c = 0; n_cs = 0; n_we = 0; n_oe = 0; e_cs = 0; e_we = 0; e_oe = 0;
        pwe = sram_we[k]; pad = sram_addr[k]; pdin = sram_din[k];
        while (nleft > 0 && c < 80) begin
            @(posedge clk); @(negedge clk); c++;
            n_cs += int'(sram_cs[k]);
            n_we += int'(sram_we[k]);
            n_oe += int'(sram_oe[k]);
            if (pwe && !sram_we[k]) begin
                chk("we_fall_addr", sram_addr[k], pad);
                chk("we_fall_din", sram_din[k], pdin);
            end
            pwe = sram_we[k]; pad = sram_addr[k]; pdin = sram_din[k];
            if (if_ack[k] || dm_ack[k]) begin
                chk("one_ack", if_ack[k] & dm_ack[k], 0);
                p = dm_ack[k] ? 1 : 0;
                chk("winner", p, cur);
                chk("latency", c, exp_c);
                a   = (cur == 1) ? da : ia;
                w   = (cur == 1) ? dwe : 1'b0;
                mis = (a[1:0] != 2'b00);
                if (mis) exp_rd[k][cur] = '0;
                else if (w) begin
                    ref_mem[a[9:2]] = dwd;
                    e_we += wc(k) + 1;
                end else begin
                    exp_rd[k][cur] = ref_mem[a[9:2]];
                    e_oe += wc(k) + 1;
                end
                if (!mis) e_cs += wc(k) + 1;
                chk("err", (cur == 1) ? dm_err[k] : if_err[k], mis);
                chk("rdata", (cur == 1) ? dm_rdata[k] : if_rdata[k], exp_rd[k][cur]);
                chk("rdata_other", (cur == 1) ? if_rdata[k] : dm_rdata[k], exp_rd[k][1-cur]);
                if (cur == 1) dm_req[k] = 1'b0;
                else          if_req[k] = 1'b0;
                lg[k] = cur;
                nleft--;
                if (nleft > 0) begin
                    cur   = 1 - cur;
                    exp_c = c + 1 + lat(k, (cur == 1) ? da : ia);
                end
            end
        end
        if (nleft > 0) chk("ack_timeout", nleft, 0);
        chk("cs_cycles", n_cs, e_cs);
        chk("we_cycles", n_we, e_we);
        chk("oe_cycles", n_oe, e_oe);
        @(posedge clk); @(negedge clk);
        chk("idle_after", {busy[k], if_ack[k], dm_ack[k]}, 0);
    endtask

    task automatic rand_txns(int k, int n);
        bit ion, don, dwe;
        logic [31:0] ia, da;
        for (int i = 0; i < n; i++) begin
            ion = 1'($urandom_range(0, 1));
            don = 1'($urandom_range(0, 1));
            if (!ion && !don) ion = 1'b1;
            ia = 32'($urandom_range(0, 15)) << 2;
            da = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) ia[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) da[1:0] = 2'($urandom_range(1, 3));
            dwe = 1'($urandom_range(0, 1));
            transact(k, ion, ia, don, da, dwe, $urandom);
        end
    endtask

    initial begin
        mem_load = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
            if_addr[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_load = 1'b0;
        for (int k = 0; k < 3; k++) outs_zero(k);
        rst = 1'b0;

        // tie from reset: DM, IF, DM, IF
        transact(0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 32'h0);
        transact(0, 1'b1, 32'h14, 1'b1, 32'h24, 1'b0, 32'h0);

        // IF read of 0x4 while dm_we is high on an idle DM port
        transact(0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 32'hFFFF_0000);
        chk("if_read_0x4", if_rdata[0], 32'h2001_0005);

        transact(0, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b1, 32'hDEAD_BEEF);
        transact(0, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b0, 32'h0);
        chk("dm_readback", dm_rdata[0], 32'hDEAD_BEEF);

        // misaligned DM, then a tie must go to IF
        transact(0, 1'b0, 32'h0, 1'b1, 32'h6, 1'b0, 32'h0);
        transact(0, 1'b1, 32'h8, 1'b1, 32'hC, 1'b0, 32'h0);

        transact(0, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b1, 32'h1234_5678);
        transact(0, 1'b1, 32'hA0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("if_sees_dm_write", if_rdata[0], 32'h1234_5678);

        // reset in the second ACCESS cycle of an IF read
        if_req[0] = 1'b1; if_addr[0] = 32'h4;
        @(posedge clk); @(negedge clk);
        chk("rst_cs_up", sram_cs[0], 1'b1);
        @(posedge clk); @(negedge clk);
        rst = 1'b1; if_req[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        outs_zero(0);
        rst = 1'b0;
        model_reset();
        transact(0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0);

        rand_txns(0, 30);

        transact(1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0);
        transact(1, 1'b1, 32'h30, 1'b1, 32'h30, 1'b1, 32'hCAFE_F00D);
        rand_txns(1, 10);

        transact(2, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0);
        transact(2, 1'b0, 32'h0, 1'b1, 32'h3C, 1'b1, 32'h0BAD_CAFE);
        transact(2, 1'b1, 32'h3C, 1'b1, 32'h3D, 1'b0, 32'h0);
        rand_txns(2, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single-ported `sram` between the pipeline's instruction-fetch port (IF) and data-memory port (DM). It accepts word requests on each port with a req/ack handshake, grants one at a time, and drives `sram` cs/oe/we/addr/din for a programmable number of cycles. It captures `dout` for reads and returns one ack per transaction. It sits between the pipeline stages and the `sram` instance, and its busy output feeds the hazard/stall logic.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles the SRAM strobes are held beyond the first access cycle; legal range 0–15.
- `ADDR_W`, default 32: address width, matching `sram.addr`.
- `DATA_W`, default 32: data width, matching `sram.din`/`sram.dout`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `if_req` / `dm_req` input 1: request valid; held with its payload until the matching ack.
- `if_addr` / `dm_addr` input ADDR_W: byte address; must be word-aligned.
- `dm_we` input 1: 1 = write, 0 = read. IF is read-only.
- `dm_wdata` input DATA_W: write data.
- `if_ack` / `dm_ack` output 1: one-cycle completion pulse.
- `if_rdata` / `dm_rdata` output DATA_W: read data; valid in the ack cycle and held until the port's next read completes.
- `if_err` / `dm_err` output 1: valid with ack; 1 = misaligned address, no SRAM access was made.
- `busy` output 1: high in any state other than IDLE.
- `sram_cs`, `sram_oe`, `sram_we` output 1: SRAM strobes.
- `sram_addr` output ADDR_W: SRAM address.
- `sram_din` output DATA_W: SRAM write data.
- `sram_dout` input DATA_W: SRAM read data.

## Operation
- FSM states:
  - IDLE: sample requests, pick a winner, latch its addr, we and wdata.
  - ACCESS: drive the SRAM; the wait counter counts down from WAIT_CYCLES.
  - DONE: pulse the ack.
- Arbitration in IDLE:
  - Only one port requesting: that port wins.
  - Both requesting: the port opposite to `last_grant` wins.
  - `last_grant` resets to IF, so DM wins the first tie.
- Misaligned winner (`addr[1:0] != 0`): IDLE → DONE directly; err=1, rdata=0, SRAM untouched.
- Aligned winner: IDLE → ACCESS.
  - `sram_addr`/`sram_din` are loaded in the same edge that raises cs.
  - oe = !we; we = latched we.
- ACCESS lasts WAIT_CYCLES+1 cycles.
  - Read data: `sram_dout` is registered into the winner's rdata on the final ACCESS edge.
  - On that edge, cs/oe/we go to 0. `sram_addr`/`sram_din` hold their value, so the SRAM sees no spurious address change while we=1.
- DONE: winner's ack = 1 for one cycle; `last_grant` is updated; next state is IDLE.
- Requester rules:
  - Drop req, or present a new request, in the cycle after ack.
  - Req seen in IDLE is always treated as a new transaction.
- IF requests with `dm_we` have no effect; IF never writes.
- `last_grant` updates on misaligned errors too.

## Timing
- Reset values: all outputs 0, `sram_addr`/`sram_din` = 0, state IDLE, counter 0, `last_grant` = IF.
- Reset mid-operation (ACCESS or DONE): next cycle is IDLE with strobes 0. No ack is issued; the requester must reissue.
- Latency:
  - Aligned access: req seen at edge N → cs high from N, ack in cycle N+WAIT_CYCLES+2.
  - With WAIT_CYCLES=1, ack arrives 3 cycles after the request edge.
  - Misaligned: ack at N+1.
- Back-to-back throughput: one transaction per WAIT_CYCLES+3 cycles (IDLE + ACCESS + DONE).
- A request arriving during busy is held by its requester; it is not queued internally.
- Same-address write by DM then read by IF are strictly serialised; the read observes the written data.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, ACCESS, DONE};
  - port id constants PORT_IF=0, PORT_DM=1;
  - WORD_ALIGN_MASK = 2'b11.
- Single module. The wait counter and grant logic stay inline; no sub-module is warranted.

## Test plan
- Single IF read, WAIT_CYCLES=1, SRAM holds 0x00000004→0x20010005: `if_ack` 3 cycles after req with `if_rdata`=0x20010005; cs high exactly 2 cycles, `sram_we`=0 throughout.
- DM write 0x000000A0←0xDEADBEEF, then DM read of 0x000000A0: `dm_rdata`=0xDEADBEEF; `sram_we` high exactly 2 cycles with addr/din stable across the we falling edge.
- IF and DM both requesting from reset, for 4 consecutive transactions: grant order DM, IF, DM, IF; never two acks in the same cycle.
- DM read of 0x00000006: `dm_ack`+`dm_err` one cycle after req, `dm_rdata`=0, cs never asserted; `last_grant`=DM.
- rst asserted in the 2nd ACCESS cycle of an IF read: next cycle all outputs 0, no `if_ack`; the reissued request completes normally.
- WAIT_CYCLES=0 and WAIT_CYCLES=15 builds: ack latencies of 2 and 17 cycles respectively, with correct read data.
